// File: rtl/mem_cycle_unit_if.sv
// Signal bundle between the CPU core, the memory-bus cycle engine and the external
// memory bus control lines. Word-wide fields use [0:15] numbering, bit 0 = MSB.
interface mem_cycle_unit_if;
  logic        read_request;
  logic        write_request;
  logic [0:15] wdata;
  logic [0:15] rdata;
  logic        read_done;
  logic        write_done;
  logic        phi1;
  logic        phi2;
  logic        phi3;
  logic        phi4;
  logic        memen_n;
  logic        dbin;
  logic        we_n;
  logic        a15;

  // master: the requesting side (CPU core); slave: the cycle engine itself
  modport master (
    output read_request, write_request, wdata,
    input  rdata, read_done, write_done,
    input  phi1, phi2, phi3, phi4,
    input  memen_n, dbin, we_n, a15
  );

  modport slave (
    input  read_request, write_request, wdata,
    output rdata, read_done, write_done,
    output phi1, phi2, phi3, phi4,
    output memen_n, dbin, we_n, a15
  );
endinterface

// File: rtl/mem_cycle_unit.sv
// Memory-bus cycle engine: four-phase clock generator plus a sequencer that moves one
// 16-bit word per request over an 8-bit multiplexed bus as two phase-aligned byte cycles.
module mem_cycle_unit (
  input  logic            clk12,
  input  logic            rst,
  mem_cycle_unit_if.slave bus,
  inout  wire  [0:7]      data_bus
);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_PHI1,
    BYTE0,
    BYTE1,
    DONE
  } seq_state_t;

  seq_state_t  state_reg;
  seq_state_t  state_next;
  logic [1:0]  phase_cnt_reg;
  logic [3:0]  phi_reg;
  logic [3:0]  phi_next;
  logic        is_read_reg;
  logic        is_read_next;
  logic [0:15] wbuf_reg;
  logic [0:15] wbuf_next;
  logic [0:15] rdata_reg;
  logic [0:15] rdata_next;

  logic        phi1_at_next_edge;
  logic        memen_n_c;
  logic        dbin_c;
  logic        we_n_c;
  logic        a15_c;
  logic        read_done_c;
  logic        write_done_c;
  logic        bus_drive;
  logic [0:7]  bus_out;

  // The counter names the phase the next edge will raise, so phi_reg[0] (phi1)
  // follows the edge taken with the counter at zero.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_phase_decode
      assign phi_next[gi] = (phase_cnt_reg == 2'(gi));
    end
  endgenerate

  assign phi1_at_next_edge = (phase_cnt_reg == 2'd0);

  always_ff @(posedge clk12 or posedge rst) begin
    if (rst) begin
      phase_cnt_reg <= 2'd0;
      phi_reg       <= 4'd0;
    end else begin
      phase_cnt_reg <= phase_cnt_reg + 2'd1;
      phi_reg       <= phi_next;
    end
  end

  always_ff @(posedge clk12 or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      is_read_reg <= 1'b0;
      wbuf_reg    <= '0;
      rdata_reg   <= '0;
    end else begin
      state_reg   <= state_next;
      is_read_reg <= is_read_next;
      wbuf_reg    <= wbuf_next;
      rdata_reg   <= rdata_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    is_read_next = is_read_reg;
    wbuf_next    = wbuf_reg;
    rdata_next   = rdata_reg;
    memen_n_c    = 1'b1;
    dbin_c       = 1'b0;
    we_n_c       = 1'b1;
    a15_c        = 1'b0;
    read_done_c  = 1'b0;
    write_done_c = 1'b0;
    bus_drive    = 1'b0;
    bus_out      = 8'h00;

    case (state_reg)
      IDLE: begin
        // A read outranks a simultaneous write; the write request is simply dropped.
        if (bus.read_request || bus.write_request) begin
          is_read_next = bus.read_request;
          if (!bus.read_request) begin
            wbuf_next = bus.wdata;
          end
          state_next = WAIT_PHI1;
        end
      end

      WAIT_PHI1: begin
        if (phi1_at_next_edge) begin
          state_next = BYTE0;
        end
      end

      BYTE0, BYTE1: begin
        memen_n_c = 1'b0;
        a15_c     = (state_reg == BYTE1);
        if (is_read_reg) begin
          dbin_c = 1'b1;
          // Memory data is taken on the edge that closes phi3.
          if (phi_reg[2]) begin
            if (state_reg == BYTE0) begin
              rdata_next[0:7] = data_bus;
            end else begin
              rdata_next[8:15] = data_bus;
            end
          end
        end else begin
          bus_drive = 1'b1;
          bus_out   = (state_reg == BYTE1) ? wbuf_reg[8:15] : wbuf_reg[0:7];
          we_n_c    = !(phi_reg[1] || phi_reg[2]);
        end
        if (phi1_at_next_edge) begin
          state_next = (state_reg == BYTE0) ? BYTE1 : DONE;
        end
      end

      DONE: begin
        read_done_c  = is_read_reg;
        write_done_c = !is_read_reg;
        state_next   = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  generate
    for (gi = 0; gi < 8; gi++) begin : g_bus_tristate
      assign data_bus[gi] = bus_drive ? bus_out[gi] : 1'bz;
    end
  endgenerate

  assign bus.phi1       = phi_reg[0];
  assign bus.phi2       = phi_reg[1];
  assign bus.phi3       = phi_reg[2];
  assign bus.phi4       = phi_reg[3];
  assign bus.memen_n    = memen_n_c;
  assign bus.dbin       = dbin_c;
  assign bus.we_n       = we_n_c;
  assign bus.a15        = a15_c;
  assign bus.read_done  = read_done_c;
  assign bus.write_done = write_done_c;
  assign bus.rdata      = rdata_reg;

endmodule

// File: tb/tb_mem_cycle_unit.sv
// Bench for mem_cycle_unit: per-cycle comparison against an edge-count timeline model,
// a table of whole-word transactions, hand-written busy/reset sequences and random traffic.
module tb_mem_cycle_unit;

  localparam logic [0:7] SENTINEL = 8'h5A;

  logic       clk12 = 1'b0;
  logic       rst;
  wire  [0:7] data_bus;
  logic       tb_bus_en;
  logic [0:7] tb_bus_val;

  mem_cycle_unit_if intf ();

  mem_cycle_unit dut (
    .clk12    (clk12),
    .rst      (rst),
    .bus      (intf),
    .data_bus (data_bus)
  );

  // Memory side of the bus: returns read bytes, otherwise holds a known pattern so
  // any stray drive from the unit shows up as a changed value.
  assign data_bus = tb_bus_en ? tb_bus_val : 8'bz;

  always #5 clk12 = ~clk12;

  typedef struct {
    logic        rq;
    logic        wq;
    logic [0:15] wd;
    logic [0:7]  m0;
    logic [0:7]  m1;
    logic [0:15] exp_rdata;
    int          exp_rd;
    int          exp_wr;
    int          exp_memen;
    int          exp_dbin;
    int          exp_we;
    logic [0:7]  exp_b0;
    logic [0:7]  exp_b1;
  } vec_t;

  vec_t vecs [5];

  int checks = 0;
  int errors = 0;

  // Timeline model: everything is derived from the number of edges since reset release.
  int          edge_n;
  logic        txn_active;
  logic        txn_read;
  int          txn_s;
  logic [0:15] txn_wd;
  logic [0:15] m_rdata;
  logic [0:7]  mem_b0;
  logic [0:7]  mem_b1;
  logic        rand_mem;

  int          c_rd, c_wr, c_memen, c_dbin, c_we, done_edge, req_edge;
  logic [0:7]  cap_b0, cap_b1;
  int          n1, n2, n3, n4, ovl;
  logic        wq_en, after_done;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  task automatic model_reset();
    edge_n     = 0;
    txn_active = 1'b0;
    txn_read   = 1'b0;
    txn_s      = 0;
    m_rdata    = '0;
  endtask

  task automatic model_edge(input logic rq, input logic wq, input logic [0:15] wd);
    edge_n++;
    if (txn_active && txn_read) begin
      if (edge_n == txn_s + 3) m_rdata[0:7] = mem_b0;
      if (edge_n == txn_s + 7) m_rdata[8:15] = mem_b1;
    end
    // The edge that closes the done cycle still sees a busy unit.
    if (txn_active && edge_n > txn_s + 9) txn_active = 1'b0;
    if (!txn_active && (rq || wq)) begin
      txn_active = 1'b1;
      txn_read   = rq;
      txn_wd     = wd;
      txn_s      = edge_n + 1;
      while (((txn_s - 1) % 4) != 0) txn_s++;
      if (rq && rand_mem) begin
        mem_b0 = 8'($urandom);
        mem_b1 = 8'($urandom);
      end
    end
  endtask

  task automatic clear_counters();
    c_rd = 0; c_wr = 0; c_memen = 0; c_dbin = 0; c_we = 0;
    done_edge = -100; cap_b0 = 8'h00; cap_b1 = 8'h00;
  endtask

  task automatic settle_check();
    logic [3:0] e_phi;
    logic       e_byte, e_b1, e_done;
    int         k;
    logic [0:7] e_bus;
    e_phi = 4'd0; e_byte = 1'b0; e_b1 = 1'b0; e_done = 1'b0; k = 0;
    if (edge_n > 0) e_phi = 4'b0001 << ((edge_n - 1) % 4);
    if (txn_active) begin
      if (edge_n >= txn_s && edge_n <= txn_s + 7) begin
        e_byte = 1'b1;
        e_b1   = (edge_n >= txn_s + 4);
        k      = (edge_n - txn_s) % 4;
      end else if (edge_n == txn_s + 8) begin
        e_done = 1'b1;
      end
    end
    if (e_byte && !txn_read) begin
      tb_bus_en  = 1'b0;
      tb_bus_val = SENTINEL;
      e_bus      = e_b1 ? txn_wd[8:15] : txn_wd[0:7];
    end else begin
      tb_bus_en  = 1'b1;
      tb_bus_val = !e_byte ? SENTINEL : (e_b1 ? mem_b1 : mem_b0);
      e_bus      = tb_bus_val;
    end
    #1;
    chk("phi",        {28'd0, intf.phi4, intf.phi3, intf.phi2, intf.phi1}, {28'd0, e_phi});
    chk("memen_n",    32'(intf.memen_n),    32'(!e_byte));
    chk("dbin",       32'(intf.dbin),       32'(e_byte && txn_read));
    chk("we_n",       32'(intf.we_n),       32'(!(e_byte && !txn_read && (k == 1 || k == 2))));
    chk("a15",        32'(intf.a15),        32'(e_b1));
    chk("read_done",  32'(intf.read_done),  32'(e_done && txn_read));
    chk("write_done", 32'(intf.write_done), 32'(e_done && !txn_read));
    chk("rdata",      32'(intf.rdata),      32'(m_rdata));
    chk("data_bus",   32'(data_bus),        32'(e_bus));
    if (!intf.memen_n) c_memen++;
    if (intf.dbin) c_dbin++;
    if (!intf.we_n) begin
      c_we++;
      if (intf.a15) cap_b1 = data_bus;
      else          cap_b0 = data_bus;
    end
    if (intf.read_done) begin
      c_rd++;
      done_edge = edge_n;
      $display("txn read  complete: rdata=%h edge=%0d", intf.rdata, edge_n);
    end
    if (intf.write_done) begin
      c_wr++;
      done_edge = edge_n;
      $display("txn write complete: wdata=%h edge=%0d", txn_wd, edge_n);
    end
  endtask

  task automatic cycle(input logic rq, input logic wq, input logic [0:15] wd);
    intf.read_request  = rq;
    intf.write_request = wq;
    intf.wdata         = wd;
    @(posedge clk12);
    model_edge(rq, wq, wd);
    @(negedge clk12);
    intf.read_request  = 1'b0;
    intf.write_request = 1'b0;
    settle_check();
  endtask

  // Called mid-cycle; the first check runs 1 time unit after rst rises.
  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    settle_check();
    repeat (2) @(posedge clk12);
    @(negedge clk12);
    rst = 1'b0;
    settle_check();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion, required finish within time limit");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{1'b1, 1'b0, 16'h0000, 8'h12, 8'h34, 16'h1234, 1, 0, 8, 8, 0, 8'h00, 8'h00};
    vecs[1] = '{1'b0, 1'b1, 16'hC003, 8'h00, 8'h00, 16'h1234, 0, 1, 8, 0, 4, 8'hC0, 8'h03};
    vecs[2] = '{1'b1, 1'b1, 16'hFFFF, 8'hAB, 8'hCD, 16'hABCD, 1, 0, 8, 8, 0, 8'h00, 8'h00};
    vecs[3] = '{1'b0, 1'b1, 16'h9E61, 8'h00, 8'h00, 16'hABCD, 0, 1, 8, 0, 4, 8'h9E, 8'h61};
    vecs[4] = '{1'b1, 1'b0, 16'h7777, 8'h00, 8'hFF, 16'h00FF, 1, 0, 8, 8, 0, 8'h00, 8'h00};

    rst                = 1'b1;
    intf.read_request  = 1'b0;
    intf.write_request = 1'b0;
    intf.wdata         = 16'h0000;
    tb_bus_en          = 1'b1;
    tb_bus_val         = SENTINEL;
    rand_mem           = 1'b0;
    mem_b0             = 8'h00;
    mem_b1             = 8'h00;
    txn_wd             = 16'h0000;
    model_reset();
    clear_counters();
    @(negedge clk12);
    settle_check();
    @(negedge clk12);
    rst = 1'b0;
    settle_check();

    // Free-running phases: each phi once per four cycles, never two together.
    n1 = 0; n2 = 0; n3 = 0; n4 = 0; ovl = 0;
    for (int i = 0; i < 16; i++) begin
      cycle(1'b0, 1'b0, 16'($urandom));
      n1 += int'(intf.phi1); n2 += int'(intf.phi2);
      n3 += int'(intf.phi3); n4 += int'(intf.phi4);
      if ((int'(intf.phi1) + int'(intf.phi2) + int'(intf.phi3) + int'(intf.phi4)) != 1) ovl++;
    end
    chk("phi1_count", n1, 4);
    chk("phi2_count", n2, 4);
    chk("phi3_count", n3, 4);
    chk("phi4_count", n4, 4);
    chk("phi_one_hot", ovl, 0);

    for (int v = 0; v < 5; v++) begin
      repeat ($urandom_range(0, 3)) cycle(1'b0, 1'b0, 16'($urandom));
      mem_b0 = vecs[v].m0;
      mem_b1 = vecs[v].m1;
      clear_counters();
      cycle(vecs[v].rq, vecs[v].wq, vecs[v].wd);
      req_edge = edge_n;
      for (int i = 0; i < 14; i++) cycle(1'b0, 1'b0, 16'($urandom));
      chk("vec_read_done",  c_rd,    vecs[v].exp_rd);
      chk("vec_write_done", c_wr,    vecs[v].exp_wr);
      chk("vec_memen_cyc",  c_memen, vecs[v].exp_memen);
      chk("vec_dbin_cyc",   c_dbin,  vecs[v].exp_dbin);
      chk("vec_we_cyc",     c_we,    vecs[v].exp_we);
      chk("vec_byte0",      32'(cap_b0), 32'(vecs[v].exp_b0));
      chk("vec_byte1",      32'(cap_b1), 32'(vecs[v].exp_b1));
      chk("vec_rdata",      32'(intf.rdata), 32'(vecs[v].exp_rdata));
      chk("vec_latency",    32'((done_edge - req_edge) >= 9 && (done_edge - req_edge) <= 12), 32'd1);
      $display("vector %0d: rq=%0b wq=%0b wdata=%h rdata=%h latency=%0d",
               v, vecs[v].rq, vecs[v].wq, vecs[v].wd, intf.rdata, done_edge - req_edge);
    end

    // Write requests during a read, including on the edge that ends the done cycle.
    mem_b0 = 8'h3C; mem_b1 = 8'hA9;
    clear_counters();
    wq_en = 1'b1; after_done = 1'b0;
    for (int i = 0; i < 14; i++) begin
      cycle(i == 0, (i > 0) && wq_en, 16'($urandom));
      if (after_done) wq_en = 1'b0;
      if (intf.read_done) after_done = 1'b1;
    end
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 16'($urandom));
    chk("busy_read_done",  c_rd, 1);
    chk("busy_write_done", c_wr, 0);
    chk("busy_rdata", 32'(intf.rdata), 32'h3CA9);
    $display("busy sequence: read_done=%0d write_done=%0d", c_rd, c_wr);

    // Reset while the second byte of a write is on the bus.
    clear_counters();
    cycle(1'b0, 1'b1, 16'hBEEF);
    for (int i = 0; i < 20 && !(intf.a15 && !intf.memen_n); i++) cycle(1'b0, 1'b0, 16'($urandom));
    chk("rst_reached_byte1", 32'(intf.a15 && !intf.memen_n), 32'd1);
    do_reset();
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 16'($urandom));
    chk("rst_no_write_done", c_wr, 0);
    mem_b0 = 8'h56; mem_b1 = 8'h78;
    clear_counters();
    cycle(1'b1, 1'b0, 16'($urandom));
    for (int i = 0; i < 14; i++) cycle(1'b0, 1'b0, 16'($urandom));
    chk("post_rst_read_done", c_rd, 1);
    chk("post_rst_rdata", 32'(intf.rdata), 32'h5678);
    $display("reset sequence: read after reset rdata=%h", intf.rdata);

    // Random traffic, including requests that land while the unit is busy.
    rand_mem = 1'b1;
    for (int i = 0; i < 500; i++) begin
      cycle($urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0, 16'($urandom));
    end
    rand_mem = 1'b0;
    for (int i = 0; i < 14; i++) cycle(1'b0, 1'b0, 16'($urandom));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
